// File: rtl/hazard_fwd_ctrl.sv
// Pipeline control for the IF|DE|MW core: operand/writeback mux selects,
// MW-to-DE forwarding, memory-wait stall with timeout fault, and branch flush.
module hazard_fwd_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de_valid,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       de_rs1_en,
  input  logic       de_rs2_en,
  input  logic [1:0] de_a_kind,
  input  logic [1:0] de_b_kind,
  input  logic [4:0] de_rd,
  input  logic       de_reg_wr,
  input  logic       de_mem_op,
  input  logic [1:0] de_wb_sel,
  input  logic       de_br_taken,
  input  logic       mem_ready,
  input  logic       fault_clr,
  output logic [1:0] op_a_sel,
  output logic [1:0] op_b_sel,
  output logic       sd_fwd,
  output logic [1:0] wb_sel,
  output logic       rf_we,
  output logic       stall,
  output logic       flush_de,
  output logic       mem_fault
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mw_valid_q, mw_valid_d;
  logic [4:0]       mw_rd_q, mw_rd_d;
  logic             mw_reg_wr_q, mw_reg_wr_d;
  logic             mw_mem_op_q, mw_mem_op_d;
  logic [1:0]       mw_wb_sel_q, mw_wb_sel_d;
  logic             mem_fault_q, mem_fault_d;

  logic       hit_a, hit_b, stall_c;
  logic [1:0] a_sel, b_sel;

  always_comb begin
    hit_a = mw_valid_q & mw_reg_wr_q & (mw_rd_q != 5'd0) & de_rs1_en & (de_rs1 == mw_rd_q);
    hit_b = mw_valid_q & mw_reg_wr_q & (mw_rd_q != 5'd0) & de_rs2_en & (de_rs2 == mw_rd_q);

    case (de_a_kind)
      2'b01:   a_sel = 2'b10;
      2'b10:   a_sel = 2'b11;
      default: a_sel = hit_a ? 2'b01 : 2'b00;
    endcase

    case (de_b_kind)
      2'b01, 2'b11: b_sel = 2'b10;
      2'b10:        b_sel = 2'b11;
      default:      b_sel = hit_b ? 2'b01 : 2'b00;
    endcase

    stall_c = ((state_q == RUN) & mw_valid_q & mw_mem_op_q & ~mem_ready)
            | ((state_q == MEM_WAIT) & ~mem_ready)
            | ((state_q == FAULT) & ~fault_clr);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN:
        if (mw_valid_q & mw_mem_op_q & ~mem_ready) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      MEM_WAIT:
        if (mem_ready)                             state_d = RUN;
        else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = FAULT;
        else                                       cnt_d   = cnt_q + 1'b1;
      FAULT:
        if (fault_clr) state_d = RUN;
      default: state_d = RUN;
    endcase
    mem_fault_d = (state_d == FAULT);

    // On fault_clr the stall drops, so the faulting entry is overwritten by DE.
    mw_valid_d  = stall_c ? mw_valid_q  : de_valid;
    mw_rd_d     = stall_c ? mw_rd_q     : de_rd;
    mw_reg_wr_d = stall_c ? mw_reg_wr_q : de_reg_wr;
    mw_mem_op_d = stall_c ? mw_mem_op_q : de_mem_op;
    mw_wb_sel_d = stall_c ? mw_wb_sel_q : de_wb_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      mw_valid_q  <= 1'b0;
      mw_rd_q     <= 5'd0;
      mw_reg_wr_q <= 1'b0;
      mw_mem_op_q <= 1'b0;
      mw_wb_sel_q <= 2'b00;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mw_valid_q  <= mw_valid_d;
      mw_rd_q     <= mw_rd_d;
      mw_reg_wr_q <= mw_reg_wr_d;
      mw_mem_op_q <= mw_mem_op_d;
      mw_wb_sel_q <= mw_wb_sel_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Kind-driven selects and flush follow DE inputs directly; force them low in reset.
  assign op_a_sel  = rst_n ? a_sel : 2'b00;
  assign op_b_sel  = rst_n ? b_sel : 2'b00;
  assign sd_fwd    = rst_n & hit_b & de_mem_op;
  assign wb_sel    = mw_wb_sel_q;
  assign stall     = stall_c;
  assign rf_we     = mw_valid_q & mw_reg_wr_q & ~stall_c & (state_q != FAULT);
  assign flush_de  = rst_n & de_valid & de_br_taken & ~stall_c;
  assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl (MEM_TIMEOUT=4): forwarding selects,
// memory stall, timeout fault, branch flush and async reset.
module tb_hazard_fwd_ctrl;
  logic       clk, rst_n;
  logic       de_valid, de_rs1_en, de_rs2_en, de_reg_wr, de_mem_op, de_br_taken;
  logic [4:0] de_rs1, de_rs2, de_rd;
  logic [1:0] de_a_kind, de_b_kind, de_wb_sel;
  logic       mem_ready, fault_clr;
  logic [1:0] op_a_sel, op_b_sel, wb_sel;
  logic       sd_fwd, rf_we, stall, flush_de, mem_fault;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_fwd_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_en(de_rs1_en), .de_rs2_en(de_rs2_en),
    .de_a_kind(de_a_kind), .de_b_kind(de_b_kind),
    .de_rd(de_rd), .de_reg_wr(de_reg_wr), .de_mem_op(de_mem_op),
    .de_wb_sel(de_wb_sel), .de_br_taken(de_br_taken),
    .mem_ready(mem_ready), .fault_clr(fault_clr),
    .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .sd_fwd(sd_fwd),
    .wb_sel(wb_sel), .rf_we(rf_we), .stall(stall),
    .flush_de(flush_de), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic de_idle();
    de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_en = 0; de_rs2_en = 0;
    de_a_kind = 0; de_b_kind = 0; de_rd = 0; de_reg_wr = 0; de_mem_op = 0;
    de_wb_sel = 0; de_br_taken = 0;
  endtask

  task automatic de_instr(input logic [4:0] rd, input logic wr, input logic mop,
                          input logic [1:0] wbs);
    de_idle();
    de_valid = 1; de_rd = rd; de_reg_wr = wr; de_mem_op = mop; de_wb_sel = wbs;
  endtask

  initial begin
    rst_n = 0; mem_ready = 1; fault_clr = 0;
    de_idle();
    de_valid = 1; de_a_kind = 2'b01; de_b_kind = 2'b10; de_br_taken = 1;
    #2;
    chk("rst op_a_sel", op_a_sel, 0);
    chk("rst op_b_sel", op_b_sel, 0);
    chk("rst flush_de", flush_de, 0);
    chk("rst stall", stall, 0);
    chk("rst mem_fault", mem_fault, 0);
    chk("rst rf_we", rf_we, 0);
    #10 rst_n = 1;
    de_idle();

    // 1: MW add x5 forwards to rs1
    de_instr(5'd5, 1, 0, 2'b00);
    step();
    de_idle(); de_valid = 1; de_rs1 = 5; de_rs1_en = 1; #1;
    chk("t1 hitA", op_a_sel, 1);
    chk("t1 rf_we", rf_we, 1);
    chk("t1 op_b none", op_b_sel, 0);
    de_a_kind = 2'b01; #1; chk("t1 pc", op_a_sel, 2);
    de_a_kind = 2'b10; #1; chk("t1 zero", op_a_sel, 3);
    de_a_kind = 2'b11; #1; chk("t1 kind11", op_a_sel, 1);
    de_a_kind = 2'b00; de_rs1_en = 0; #1; chk("t1 rs1_en0", op_a_sel, 0);
    de_instr(5'd0, 1, 0, 2'b00);
    step();
    de_idle(); de_valid = 1; de_rs1 = 0; de_rs1_en = 1; #1;
    chk("t1 rd0", op_a_sel, 0);

    // 5: store forwarding rs2 from MW rd=9
    de_instr(5'd9, 1, 0, 2'b00);
    step();
    de_idle(); de_valid = 1; de_mem_op = 1; de_rs2 = 9; de_rs2_en = 1; de_b_kind = 2'b01; #1;
    chk("t5 imm", op_b_sel, 2);
    chk("t5 sd_fwd", sd_fwd, 1);
    de_b_kind = 2'b00; #1; chk("t5 hitB", op_b_sel, 1);
    de_b_kind = 2'b10; #1; chk("t5 c4", op_b_sel, 3);
    de_b_kind = 2'b11; #1; chk("t5 kind11", op_b_sel, 2);
    de_mem_op = 0; #1; chk("t5 no mem", sd_fwd, 0);
    de_rs2 = 8; de_mem_op = 1; #1; chk("t5 rs2 miss", sd_fwd, 0);

    // 2: load x7 waits three cycles
    de_instr(5'd7, 1, 1, 2'b01);
    step();
    de_idle(); mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2 stall", stall, 1);
      chk("t2 rf_we wait", rf_we, 0);
      chk("t2 wb_sel", wb_sel, 1);
      step();
    end
    mem_ready = 1; #1;
    chk("t2 ready stall", stall, 0);
    chk("t2 ready rf_we", rf_we, 1);
    chk("t2 ready wb_sel", wb_sel, 1);
    step();
    chk("t2 after stall", stall, 0);
    chk("t2 after fault", mem_fault, 0);

    // 3: timeout fault
    de_instr(5'd3, 1, 1, 2'b01);
    step();
    de_idle(); mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3 stall", stall, 1);
      chk("t3 no fault yet", mem_fault, 0);
      chk("t3 rf_we", rf_we, 0);
      step();
    end
    chk("t3 fault", mem_fault, 1);
    chk("t3 fault stall", stall, 1);
    chk("t3 fault rf_we", rf_we, 0);
    step();
    chk("t3 fault sticky", mem_fault, 1);
    fault_clr = 1; #1;
    chk("t3 clr stall", stall, 0);
    chk("t3 clr rf_we", rf_we, 0);
    step();
    fault_clr = 0; #1;
    chk("t3 cleared", mem_fault, 0);
    chk("t3 cleared stall", stall, 0);
    chk("t3 dropped rf_we", rf_we, 0);
    mem_ready = 1;

    // 4: branch flush, free and behind a memory stall
    de_idle(); de_valid = 1; de_br_taken = 1; #1;
    chk("t4 flush", flush_de, 1);
    step();
    de_idle(); #1;
    chk("t4 flush one", flush_de, 0);
    de_instr(5'd4, 1, 1, 2'b01);
    step();
    mem_ready = 0;
    de_idle(); de_valid = 1; de_br_taken = 1; de_wb_sel = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4 held flush", flush_de, 0);
      chk("t4 held wb_sel", wb_sel, 1);
      step();
    end
    mem_ready = 1; #1;
    chk("t4 release flush", flush_de, 1);
    step();
    de_idle(); #1;
    chk("t4 post flush", flush_de, 0);
    chk("t4 branch wb_sel", wb_sel, 2);

    // 6: reset during MEM_WAIT
    de_instr(5'd6, 1, 1, 2'b01);
    step();
    de_idle(); mem_ready = 0;
    step(); step();
    de_valid = 1; de_a_kind = 2'b01; de_b_kind = 2'b10; de_br_taken = 1;
    #2 rst_n = 0; #1;
    chk("t6 op_a", op_a_sel, 0);
    chk("t6 op_b", op_b_sel, 0);
    chk("t6 sd_fwd", sd_fwd, 0);
    chk("t6 wb_sel", wb_sel, 0);
    chk("t6 rf_we", rf_we, 0);
    chk("t6 stall", stall, 0);
    chk("t6 flush", flush_de, 0);
    chk("t6 fault", mem_fault, 0);
    #3 rst_n = 1;
    de_instr(5'd6, 1, 1, 2'b01);
    step();
    de_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6 fresh stall", stall, 1);
      step();
    end
    chk("t6 fresh no fault", mem_fault, 0);
    step();
    chk("t6 fresh fault", mem_fault, 1);
    fault_clr = 1;
    step();
    fault_clr = 0; mem_ready = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
